// File: rtl/mii_rx_decoder_if.sv
// Signal bundle between an MII receive source and mii_rx_decoder: PHY-side inputs,
// byte stream, end-of-frame status and frame counters.
interface mii_rx_decoder_if;
  logic        enet_rx_dv;
  logic        enet_rx_er;
  logic [3:0]  enet_rx_data;
  logic        i_enable;
  logic        o_valid;
  logic [7:0]  o_data;
  logic        o_sop;
  logic        o_done;
  logic [10:0] o_len;
  logic        o_crc_ok;
  logic [2:0]  o_err_code;
  logic [15:0] o_frames_ok;
  logic [15:0] o_frames_bad;

  modport master (
    output enet_rx_dv, enet_rx_er, enet_rx_data, i_enable,
    input  o_valid, o_data, o_sop, o_done, o_len, o_crc_ok, o_err_code,
    input  o_frames_ok, o_frames_bad
  );

  modport slave (
    input  enet_rx_dv, enet_rx_er, enet_rx_data, i_enable,
    output o_valid, o_data, o_sop, o_done, o_len, o_crc_ok, o_err_code,
    output o_frames_ok, o_frames_bad
  );
endinterface

// File: rtl/mii_rx_decoder.sv
// MII receive decoder: strips preamble/SFD, packs nibbles into bytes, checks CRC-32 and
// reports one status strobe plus good/bad counters per frame. Single clock domain.
module mii_rx_decoder #(
  parameter int unsigned MIN_FRAME    = 64,
  parameter int unsigned MAX_FRAME    = 1522,
  parameter int unsigned MAX_PREAMBLE = 15
) (
  input logic             enet_rx_clk,
  input logic             i_reset,
  mii_rx_decoder_if.slave bus
);

  localparam int unsigned     PreW       = $clog2(MAX_PREAMBLE + 2);
  localparam logic [PreW-1:0] PreMax     = PreW'(MAX_PREAMBLE);
  localparam logic [10:0]     MaxLen     = 11'(MAX_FRAME);
  localparam logic [10:0]     MinLen     = 11'(MIN_FRAME);
  localparam logic [10:0]     LenSat     = 11'h7FF;
  localparam logic [31:0]     CrcInit    = 32'hFFFF_FFFF;
  localparam logic [31:0]     CrcResidue = 32'hDEBB_20E3;

  localparam logic [2:0] ErrOk       = 3'd0;
  localparam logic [2:0] ErrCrc      = 3'd1;
  localparam logic [2:0] ErrAlign    = 3'd2;
  localparam logic [2:0] ErrRxEr     = 3'd3;
  localparam logic [2:0] ErrRunt     = 3'd4;
  localparam logic [2:0] ErrOversize = 3'd5;

  typedef enum logic [1:0] {StDrop, StIdle, StPre, StData} state_e;

  // Reflected CRC-32, byte fed LSB first, no final inversion.
  function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
    logic [31:0] c;
    c = crc ^ {24'h0, b};
    for (int i = 0; i < 8; i++) begin
      c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
    end
    return c;
  endfunction

  state_e          state_q, state_d;
  logic [PreW-1:0] pre_cnt_q, pre_cnt_d;
  logic            phase_q, phase_d;
  logic [3:0]      low_q, low_d;
  logic [31:0]     crc_q, crc_d;
  logic [10:0]     len_q, len_d;
  logic            first_q, first_d;
  logic            er_seen_q, er_seen_d;

  logic            valid_q, valid_d;
  logic [7:0]      data_q, data_d;
  logic            sop_q, sop_d;
  logic            done_q, done_d;
  logic [10:0]     out_len_q, out_len_d;
  logic            crc_ok_q, crc_ok_d;
  logic [2:0]      err_q, err_d;
  logic [15:0]     ok_cnt_q, ok_cnt_d;
  logic [15:0]     bad_cnt_q, bad_cnt_d;

  logic [7:0]      rx_byte;
  logic            crc_match;
  logic [2:0]      err_code;

  assign rx_byte   = {bus.enet_rx_data, low_q};
  assign crc_match = (crc_q == CrcResidue);

  always_comb begin
    if (er_seen_q) begin
      err_code = ErrRxEr;
    end else if (len_q > MaxLen) begin
      err_code = ErrOversize;
    end else if (phase_q) begin
      err_code = ErrAlign;
    end else if (len_q < MinLen) begin
      err_code = ErrRunt;
    end else if (!crc_match) begin
      err_code = ErrCrc;
    end else begin
      err_code = ErrOk;
    end
  end

  always_comb begin
    state_d   = state_q;
    pre_cnt_d = pre_cnt_q;
    phase_d   = phase_q;
    low_d     = low_q;
    crc_d     = crc_q;
    len_d     = len_q;
    first_d   = first_q;
    er_seen_d = er_seen_q;
    valid_d   = 1'b0;
    sop_d     = 1'b0;
    done_d    = 1'b0;
    data_d    = data_q;
    out_len_d = out_len_q;
    crc_ok_d  = crc_ok_q;
    err_d     = err_q;
    ok_cnt_d  = ok_cnt_q;
    bad_cnt_d = bad_cnt_q;

    unique case (state_q)
      StDrop: begin
        if (!bus.enet_rx_dv) begin
          state_d = StIdle;
        end
      end

      StIdle: begin
        if (bus.enet_rx_dv) begin
          if (bus.enet_rx_data == 4'h5 && !bus.enet_rx_er && bus.i_enable) begin
            state_d   = StPre;
            pre_cnt_d = PreW'(1);
          end else begin
            state_d = StDrop;
          end
        end
      end

      StPre: begin
        if (!bus.enet_rx_dv) begin
          state_d = StIdle;
        end else if (bus.enet_rx_er) begin
          state_d = StDrop;
        end else if (bus.enet_rx_data == 4'h5) begin
          // Count would pass the limit after this nibble.
          if (pre_cnt_q >= PreMax) begin
            state_d = StDrop;
          end else begin
            pre_cnt_d = pre_cnt_q + PreW'(1);
          end
        end else if (bus.enet_rx_data == 4'hD) begin
          state_d   = StData;
          phase_d   = 1'b0;
          crc_d     = CrcInit;
          len_d     = '0;
          first_d   = 1'b1;
          er_seen_d = 1'b0;
        end else begin
          state_d = StDrop;
        end
      end

      StData: begin
        if (bus.enet_rx_dv) begin
          er_seen_d = er_seen_q | bus.enet_rx_er;
          if (!phase_q) begin
            low_d   = bus.enet_rx_data;
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            crc_d   = crc_byte(crc_q, rx_byte);
            len_d   = (len_q == LenSat) ? len_q : len_q + 11'd1;
            // Bytes past the size limit still count and feed the CRC but are not emitted.
            if (len_q < MaxLen) begin
              valid_d = 1'b1;
              data_d  = rx_byte;
              sop_d   = first_q;
              first_d = 1'b0;
            end
          end
        end else begin
          state_d   = StIdle;
          done_d    = 1'b1;
          out_len_d = len_q;
          crc_ok_d  = crc_match;
          err_d     = err_code;
          if (err_code == ErrOk) begin
            ok_cnt_d = ok_cnt_q + 16'd1;
          end else begin
            bad_cnt_d = bad_cnt_q + 16'd1;
          end
        end
      end

      default: state_d = StDrop;
    endcase
  end

  always_ff @(posedge enet_rx_clk) begin
    if (i_reset) begin
      state_q   <= StDrop;
      pre_cnt_q <= '0;
      phase_q   <= 1'b0;
      low_q     <= '0;
      crc_q     <= '0;
      len_q     <= '0;
      first_q   <= 1'b0;
      er_seen_q <= 1'b0;
      valid_q   <= 1'b0;
      data_q    <= '0;
      sop_q     <= 1'b0;
      done_q    <= 1'b0;
      out_len_q <= '0;
      crc_ok_q  <= 1'b0;
      err_q     <= '0;
      ok_cnt_q  <= '0;
      bad_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      pre_cnt_q <= pre_cnt_d;
      phase_q   <= phase_d;
      low_q     <= low_d;
      crc_q     <= crc_d;
      len_q     <= len_d;
      first_q   <= first_d;
      er_seen_q <= er_seen_d;
      valid_q   <= valid_d;
      data_q    <= data_d;
      sop_q     <= sop_d;
      done_q    <= done_d;
      out_len_q <= out_len_d;
      crc_ok_q  <= crc_ok_d;
      err_q     <= err_d;
      ok_cnt_q  <= ok_cnt_d;
      bad_cnt_q <= bad_cnt_d;
    end
  end

  assign bus.o_valid      = valid_q;
  assign bus.o_data       = data_q;
  assign bus.o_sop        = sop_q;
  assign bus.o_done       = done_q;
  assign bus.o_len        = out_len_q;
  assign bus.o_crc_ok     = crc_ok_q;
  assign bus.o_err_code   = err_q;
  assign bus.o_frames_ok  = ok_cnt_q;
  assign bus.o_frames_bad = bad_cnt_q;

endmodule
